imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
Streaming boot loader between a host/debug word stream and the instruction memory of the single-stage RV core. It holds the core in reset, writes a length-prefixed program image into instruction memory word by word, then releases the core at a parametrised boot PC. This replaces hard-coded initial preloading of the memory and PC with a synthesizable, re-triggerable load sequence.

Parameters:
XLEN, 32, data/instruction word width and boot_pc width
IMEM_DEPTH, 256, instruction memory depth in words; must be a power of two, at least 2
AW, $clog2(IMEM_DEPTH), imem word-address width (derived, not overridable)
BOOT_PC, 32'h0000_0000, value driven on boot_pc on release
RELEASE_DELAY, 2, cycles between the last memory write and cpu_rst_n rising; at least 1

Ports:
clk  in  1  system clock, shared with cpu
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  stream word valid
s_ready  out  1  loader accepts word (transfer = s_valid & s_ready)
s_data  in  XLEN  stream word: header length, then instructions
reload  in  1  single-cycle pulse; restarts the load sequence from RUN or ERROR
imem_we  out  1  instruction memory write enable
imem_addr  out  AW  word address of write
imem_wdata  out  XLEN  write data
cpu_rst_n  out  1  active-low reset to cpu; low whenever not in RUN
boot_pc  out  XLEN  next_pc value loaded by cpu on reset release
done  out  1  high in RUN
err  out  1  high in ERROR
load_count  out  AW+1  number of words written in current/last load

Behaviour:
- Reset (async, rst_n=0): state=HDR, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_n=0, boot_pc=BOOT_PC (constant), done=0, err=0, load_count=0, internal len=0, delay counter=0.
- All outputs are registered except boot_pc, which is constant. s_ready is a registered state decode: 1 in HDR and LOAD, 0 otherwise.
- HDR: on transfer, latch len=s_data. If len>IMEM_DEPTH, go to ERROR. If len==0, go to WAIT. Otherwise clear load_count and go to LOAD.
- LOAD: each transfer registers imem_we=1, imem_addr=load_count[AW-1:0], imem_wdata=s_data on the next cycle; load_count increments. The transfer that makes load_count==len goes to WAIT. There are no gaps: back-to-back transfers give one write per cycle. With s_valid=0, imem_we=0 and the state holds.
- WAIT: s_ready=0. The counter runs RELEASE_DELAY cycles from WAIT entry, then goes to RUN. The last write completes before cpu_rst_n rises.
- RUN: cpu_rst_n=1, done=1. Stream words are not accepted. reload moves to HDR with cpu_rst_n=0 and done=0 on the next edge. Memory contents are not cleared.
- ERROR: err=1, cpu_rst_n=0, s_ready=0. Only reload (to HDR, err cleared) or rst_n exits.
- reload in HDR/LOAD/WAIT: restart at HDR and clear load_count. No partial write is squashed except one that is still pending.
- len==IMEM_DEPTH is legal: the final address is IMEM_DEPTH-1 and there is no wrap. The address never exceeds len-1.
- rst_n asserted mid-LOAD: immediate return to reset values; cpu_rst_n goes low asynchronously.
- cpu_rst_n, done and err change only on clk edges, except on async reset assertion.

Decomposition:
- Shared package rv_boot_pkg: state enum (HDR, LOAD, WAIT, RUN, ERROR) and BOOT_PC default constant.
- No sub-module required. The release-delay counter stays inline.
- The top-level instantiates imem_boot_loader next to cpu. instr_memory gains a write port (we/addr/wdata). pc resets to boot_pc while cpu_rst_n=0.

Test Plan:
- Length 3 then 0x00500093, 0x00600113, 0x00000193, back-to-back -> writes at addr 0,1,2 on consecutive cycles; load_count=3; cpu_rst_n rises RELEASE_DELAY=2 cycles after WAIT entry; done=1.
- Same image with s_valid toggling every other cycle -> identical memory contents, no extra or duplicate writes, s_ready=1 throughout LOAD.
- Header 0 -> no imem_we pulses; RUN reached 2 cycles after WAIT entry.
- Header IMEM_DEPTH+1 (257) -> err=1, cpu_rst_n=0, s_ready=0. reload -> HDR, err=0.
- Header 256 with 256 words -> last write at addr 255, load_count=256. Header 256 with fewer words -> stays in LOAD.
- rst_n pulsed low after 2 of 3 words, then reload from RUN -> outputs return to reset values immediately. Subsequent reload gives cpu_rst_n=0 on the next edge and restarts at HDR.

Source files
------------

// File: rtl/rv_boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// constants, the default boot PC and a state decode helper.
package rv_boot_pkg;

  // Loader FSM states.
  localparam logic [2:0] ST_HDR   = 3'd0;  // waiting for the length header
  localparam logic [2:0] ST_LOAD  = 3'd1;  // streaming image words into imem
  localparam logic [2:0] ST_WAIT  = 3'd2;  // release delay before cpu start
  localparam logic [2:0] ST_RUN   = 3'd3;  // cpu running, loader idle
  localparam logic [2:0] ST_ERROR = 3'd4;  // oversize header, cpu held

  // Reset vector used when the top does not override BOOT_PC.
  localparam logic [31:0] BOOT_PC_DEFAULT = 32'h0000_0000;

  // The stream is accepted only while a header or image word is expected.
  function automatic logic accepts_stream(input logic [2:0] st);
    logic acc;
    case (st)
      ST_HDR:  acc = 1'b1;
      ST_LOAD: acc = 1'b1;
      default: acc = 1'b0;
    endcase
    return acc;
  endfunction

endpackage

// File: rtl/imem_boot_loader.sv
// Streaming boot loader: holds the cpu in reset, copies a length-prefixed
// image from the host stream into instruction memory, then releases the
// cpu at BOOT_PC after a short settle delay. Re-triggerable via reload.
module imem_boot_loader
  import rv_boot_pkg::*;
#(
  parameter int               XLEN          = 32,
  parameter int               IMEM_DEPTH    = 256,
  parameter logic [XLEN-1:0]  BOOT_PC       = XLEN'(BOOT_PC_DEFAULT),
  parameter int               RELEASE_DELAY = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [XLEN-1:0]               s_data,
  input  logic                          reload,
  output logic                          imem_we,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  output logic [XLEN-1:0]               imem_wdata,
  output logic                          cpu_rst_n,
  output logic [XLEN-1:0]               boot_pc,
  output logic                          done,
  output logic                          err,
  output logic [$clog2(IMEM_DEPTH):0]   load_count
);

  localparam int AW = $clog2(IMEM_DEPTH);
  // Delay counter only has to count 0 .. RELEASE_DELAY-1.
  localparam int DW = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

  logic [2:0]      state_q, state_d;
  logic [AW:0]     len_q, len_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [AW:0]     load_count_q, load_count_d;
  logic            s_ready_q, s_ready_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            cpu_rst_n_q, cpu_rst_n_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            transfer_s;
  logic [AW:0]     load_count_inc_s;

  assign transfer_s       = s_valid & s_ready_q;
  assign load_count_inc_s = load_count_q + {{AW{1'b0}}, 1'b1};

  // Next-state, write-port and counter logic for the load sequence.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    load_count_d = load_count_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    case (state_q)
      ST_HDR: begin
        if (reload) begin
          state_d      = ST_HDR;
          load_count_d = '0;
        end else if (transfer_s) begin
          // Only the low bits matter once the range check has passed.
          len_d        = s_data[AW:0];
          load_count_d = '0;
          cnt_d        = '0;
          if (s_data > XLEN'(IMEM_DEPTH)) begin
            state_d = ST_ERROR;
          end else if (s_data == '0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_HDR;
        end
      end

      ST_LOAD: begin
        if (reload) begin
          // A word offered in the same cycle as reload is dropped.
          state_d      = ST_HDR;
          load_count_d = '0;
        end else if (transfer_s) begin
          we_d         = 1'b1;
          addr_d       = load_count_q[AW-1:0];
          wdata_d      = s_data;
          load_count_d = load_count_inc_s;
          if (load_count_inc_s == len_q) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_WAIT: begin
        if (reload) begin
          state_d      = ST_HDR;
          load_count_d = '0;
        end else if (cnt_q == DW'(RELEASE_DELAY - 1)) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + {{(DW-1){1'b0}}, 1'b1};
        end
      end

      ST_RUN: begin
        if (reload) begin
          state_d = ST_HDR;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_ERROR: begin
        if (reload) begin
          state_d = ST_HDR;
        end else begin
          state_d = ST_ERROR;
        end
      end

      default: begin
        state_d      = ST_HDR;
        load_count_d = '0;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they are registered
  // yet line up exactly with the state register.
  always_comb begin
    s_ready_d   = accepts_stream(state_d);
    cpu_rst_n_d = (state_d == ST_RUN);
    done_d      = (state_d == ST_RUN);
    err_d       = (state_d == ST_ERROR);
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HDR;
      len_q        <= '0;
      cnt_q        <= '0;
      load_count_q <= '0;
      s_ready_q    <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rst_n_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      load_count_q <= load_count_d;
      s_ready_q    <= s_ready_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign boot_pc    = BOOT_PC;
  assign done       = done_q;
  assign err        = err_q;
  assign load_count = load_count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus pushes the writes an image
// should produce, a negedge monitor pops and compares every imem write.
module tb_imem_boot_loader;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 256;
  localparam int          RD    = 2;
  localparam logic [31:0] BPC   = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = 32'h0;
  logic        reload = 1'b0;
  logic        s_ready, imem_we, cpu_rst_n, done, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata, boot_pc;
  logic [8:0]  load_count;

  imem_boot_loader #(
    .XLEN(XLEN), .IMEM_DEPTH(DEPTH), .BOOT_PC(BPC), .RELEASE_DELAY(RD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n),
    .boot_pc(boot_pc), .done(done), .err(err), .load_count(load_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          we_cyc[$];
  logic [31:0] img[DEPTH];
  logic [31:0] ref_mem[DEPTH];
  logic [31:0] dut_mem[DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          rise_cyc = -1;
  int          we_total = 0;
  logic        prev_cr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every imem write must match the head of the expected queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (imem_we === 1'b1) begin
        we_total++;
        we_cyc.push_back(cyc);
        dut_mem[imem_addr] = imem_wdata;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                   imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", 64'(imem_addr), 64'(e.a));
          chk("write_data", 64'(imem_wdata), 64'(e.d));
        end
      end
      if (cpu_rst_n === 1'b1 && prev_cr === 1'b0) rise_cyc = cyc;
      prev_cr = cpu_rst_n;
    end
  end

  // Offer one word; returns the cycle number at which its effect is visible.
  task automatic send(input logic [31:0] d, output int xcyc);
    int n;
    n = 0;
    xcyc = -1;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    while (s_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (s_ready === 1'b1) begin
      xcyc = cyc + 1;
      @(posedge clk);
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got s_ready=%0b, required 1", s_ready);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("run_reached", 64'(done), 64'd1);
  endtask

  // Header then nwords image words from img[]; expected writes are queued.
  task automatic load_image(input int len, input int nwords, input bit gaps,
                            input bit rnd, output int hx, output int lx);
    int x;
    send(32'(len), hx);
    lx = hx;
    for (int i = 0; i < nwords; i++) begin
      wr_t e;
      if (gaps) begin
        @(negedge clk);
        s_valid = 1'b0;
        chk("s_ready_in_load", 64'(s_ready), 64'd1);
      end
      if (rnd) img[i] = $urandom;
      e.a = i[7:0];
      e.d = img[i];
      exp_q.push_back(e);
      ref_mem[i] = img[i];
      send(img[i], x);
      lx = x;
    end
    idle(1);
  endtask

  initial begin
    int hx, lx, w0, n;
    bit ok;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_imem_we", 64'(imem_we), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    chk("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_load_count", 64'(load_count), 64'd0);
    chk("boot_pc", 64'(boot_pc), 64'(BPC));
    rst_n = 1'b1;

    // Three-word image, back to back.
    img[0] = 32'h0050_0093;
    img[1] = 32'h0060_0113;
    img[2] = 32'h0000_0193;
    rise_cyc = -1;
    we_cyc.delete();
    load_image(3, 3, 1'b0, 1'b0, hx, lx);
    wait_done();
    chk("b2b_write_count", 64'(we_cyc.size()), 64'd3);
    if (we_cyc.size() == 3) begin
      chk("b2b_first_write", 64'(we_cyc[0] - hx), 64'd1);
      chk("b2b_consecutive", 64'(we_cyc[2] - we_cyc[0]), 64'd2);
    end
    chk("b2b_release_delay", 64'(rise_cyc - lx), 64'(RD));
    chk("b2b_load_count", 64'(load_count), 64'd3);
    chk("b2b_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
    chk("b2b_s_ready_run", 64'(s_ready), 64'd0);

    // Reload from RUN, then the same image with gaps.
    pulse_reload();
    chk("reload_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    chk("reload_done", 64'(done), 64'd0);
    chk("reload_s_ready", 64'(s_ready), 64'd1);
    for (int i = 0; i < 3; i++) dut_mem[i] = 32'hdead_beef;
    w0 = we_total;
    load_image(3, 3, 1'b1, 1'b0, hx, lx);
    wait_done();
    chk("gap_write_count", 64'(we_total - w0), 64'd3);
    for (int i = 0; i < 3; i++) chk("gap_mem", 64'(dut_mem[i]), 64'(ref_mem[i]));

    // Zero-length header.
    pulse_reload();
    w0 = we_total;
    rise_cyc = -1;
    load_image(0, 0, 1'b0, 1'b0, hx, lx);
    wait_done();
    chk("zero_no_writes", 64'(we_total - w0), 64'd0);
    chk("zero_release_delay", 64'(rise_cyc - hx), 64'(RD));
    chk("zero_load_count", 64'(load_count), 64'd0);

    // Oversize header.
    pulse_reload();
    load_image(DEPTH + 1, 0, 1'b0, 1'b0, hx, lx);
    idle(3);
    chk("ovf_err", 64'(err), 64'd1);
    chk("ovf_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    chk("ovf_s_ready", 64'(s_ready), 64'd0);
    chk("ovf_done", 64'(done), 64'd0);
    pulse_reload();
    chk("ovf_reload_err", 64'(err), 64'd0);
    chk("ovf_reload_s_ready", 64'(s_ready), 64'd1);

    // Full-depth image.
    load_image(DEPTH, DEPTH, 1'b0, 1'b1, hx, lx);
    wait_done();
    chk("full_load_count", 64'(load_count), 64'(DEPTH));
    chk("full_last_addr", 64'(imem_addr), 64'(DEPTH - 1));

    // Full-depth header with a short image stays in LOAD.
    pulse_reload();
    load_image(DEPTH, 10, 1'b0, 1'b1, hx, lx);
    idle(8);
    chk("short_done", 64'(done), 64'd0);
    chk("short_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    chk("short_s_ready", 64'(s_ready), 64'd1);
    chk("short_load_count", 64'(load_count), 64'd10);
    pulse_reload();
    chk("load_reload_count", 64'(load_count), 64'd0);
    chk("load_reload_s_ready", 64'(s_ready), 64'd1);

    // Async reset in the middle of a load.
    load_image(3, 2, 1'b0, 1'b1, hx, lx);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    chk("mid_rst_imem_we", 64'(imem_we), 64'd0);
    chk("mid_rst_load_count", 64'(load_count), 64'd0);
    chk("mid_rst_pending", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load_image(3, 3, 1'b0, 1'b1, hx, lx);
    wait_done();
    pulse_reload();
    chk("run_reload_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    chk("run_reload_done", 64'(done), 64'd0);
    chk("run_reload_s_ready", 64'(s_ready), 64'd1);

    // Random lengths, random gapping.
    for (int t = 0; t < 6; t++) begin
      n  = $urandom_range(1, 24);
      ok = ($urandom_range(0, 1) == 1);
      w0 = we_total;
      rise_cyc = -1;
      load_image(n, n, ok, 1'b1, hx, lx);
      wait_done();
      chk("rand_write_count", 64'(we_total - w0), 64'(n));
      chk("rand_load_count", 64'(load_count), 64'(n));
      chk("rand_release_delay", 64'(rise_cyc - lx), 64'(RD));
      for (int i = 0; i < n; i++) chk("rand_mem", 64'(dut_mem[i]), 64'(ref_mem[i]));
      pulse_reload();
    end

    idle(4);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
